// File: rtl/artau_pkg.sv
// Shared types and helpers for the multi-pulse radar target acquisition unit.
package artau_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT   = 2'd1,
    LISTEN = 2'd2,
    ASSESS = 2'd3
  } artau_state_e;

  // Half the speed of light, in metres per microsecond (round trip folded in).
  localparam int unsigned C_HALF_LIGHT_M_PER_US = 150;

  // Round-trip time of flight in clock cycles -> one-way distance in metres.
  function automatic logic [63:0] tof_to_metres(input logic [31:0] tof_cycles,
                                                input logic [31:0] clk_period_us);
    return 64'(tof_cycles) * 64'(clk_period_us) * 64'(C_HALF_LIGHT_M_PER_US);
  endfunction

endpackage

// File: rtl/artau_tof_timer.sv
// Loadable up-counter with a terminal-count compare, shared by every timed phase.
module artau_tof_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load has priority over counting so a phase change always starts clean.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == limit_i);

endmodule

// File: rtl/artau_multi_pulse.sv
// N-pulse radar scan controller: emit, listen for echo, convert time of flight
// to metres, and flag an approaching target inside the safe distance.
module artau_multi_pulse
  import artau_pkg::*;
#(
  parameter int unsigned CLK_PERIOD_US   = 50,
  parameter int unsigned EMIT_CYCLES     = 6,
  parameter int unsigned LISTEN_CYCLES   = 40,
  parameter int unsigned STATUS_CYCLES   = 60,
  parameter int unsigned PULSES_PER_SCAN = 2,
  parameter int unsigned DIST_W          = 32
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic                                   radar_echo,
  input  logic                                   scan_for_target,
  input  logic                                   continuous_mode,
  input  logic [DIST_W-1:0]                      max_safe_distance,
  output logic                                   radar_pulse_trigger,
  output logic [DIST_W-1:0]                      distance_to_target,
  output logic                                   threat_detected,
  output logic [1:0]                             ARTAU_state,
  output logic [$clog2(PULSES_PER_SCAN+1)-1:0]   pulse_index,
  output logic [7:0]                             scan_timeout_count
);

  localparam int unsigned PI_W    = $clog2(PULSES_PER_SCAN + 1);
  localparam int unsigned MAX_ES  = (EMIT_CYCLES > STATUS_CYCLES) ? EMIT_CYCLES : STATUS_CYCLES;
  localparam int unsigned MAX_CNT = (LISTEN_CYCLES > MAX_ES) ? LISTEN_CYCLES : MAX_ES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  artau_state_e      state_q, state_d;
  logic              trig_q, trig_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic              thr_q, thr_d;
  logic [PI_W-1:0]   pidx_q, pidx_d;
  logic [7:0]        tmo_q, tmo_d;
  logic              echo_q;

  logic              echo_edge;
  logic              more_pulses;
  logic [DIST_W-1:0] new_dist;

  logic              tm_en, tm_load, tm_tc;
  logic [CNT_W-1:0]  tm_load_val, tm_limit, tm_cnt;

  artau_tof_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i      (CLK),
    .rst_i      (RST),
    .en_i       (tm_en),
    .load_i     (tm_load),
    .load_val_i (tm_load_val),
    .limit_i    (tm_limit),
    .cnt_o      (tm_cnt),
    .tc_o       (tm_tc)
  );

  // Only a rising echo edge seen while listening counts as a return.
  assign echo_edge   = (state_q == LISTEN) && radar_echo && !echo_q;
  assign more_pulses = (32'(pidx_q) + 32'd1) < PULSES_PER_SCAN;
  // The listen counter starts at 1, so its value is the time of flight directly.
  assign new_dist    = DIST_W'(tof_to_metres(32'(tm_cnt), CLK_PERIOD_US));

  // The single timer's terminal count depends on which phase is using it.
  always_comb begin
    tm_limit = '0;
    case (state_q)
      EMIT:    tm_limit = CNT_W'(EMIT_CYCLES - 1);
      LISTEN:  tm_limit = CNT_W'(LISTEN_CYCLES);
      ASSESS:  tm_limit = CNT_W'(STATUS_CYCLES - 1);
      default: tm_limit = '0;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an echo on the last listen cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (scan_for_target) state_d = EMIT;
      EMIT:    if (tm_tc) state_d = LISTEN;
      LISTEN: begin
        if (echo_edge) begin
          state_d = more_pulses ? EMIT : ASSESS;
        end else if (tm_tc) begin
          state_d = IDLE;
        end
      end
      ASSESS: begin
        if (tm_tc) begin
          state_d = (continuous_mode && scan_for_target) ? EMIT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and timer-control logic for each phase transition.
  always_comb begin
    trig_d      = trig_q;
    dist_d      = dist_q;
    thr_d       = thr_q;
    pidx_d      = pidx_q;
    tmo_d       = tmo_q;
    tm_load     = 1'b0;
    tm_load_val = '0;
    tm_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (scan_for_target) begin
          trig_d  = 1'b1;
          pidx_d  = '0;
          tm_load = 1'b1;
        end
      end
      EMIT: begin
        if (tm_tc) begin
          trig_d      = 1'b0;
          tm_load     = 1'b1;
          tm_load_val = CNT_W'(1);
        end else begin
          tm_en = 1'b1;
        end
      end
      LISTEN: begin
        if (echo_edge) begin
          dist_d  = new_dist;
          pidx_d  = pidx_q + PI_W'(1);
          tm_load = 1'b1;
          if (more_pulses) begin
            trig_d = 1'b1;
          end else begin
            // dist_q still holds the previous echo of this scan at this point.
            thr_d = (new_dist < dist_q) && (new_dist < max_safe_distance);
          end
        end else if (tm_tc) begin
          pidx_d = '0;
          thr_d  = 1'b0;
          tmo_d  = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
        end else begin
          tm_en = 1'b1;
        end
      end
      ASSESS: begin
        if (tm_tc) begin
          pidx_d  = '0;
          tm_load = 1'b1;
          if (continuous_mode && scan_for_target) begin
            trig_d = 1'b1;
          end
        end else begin
          tm_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs, statistics and the echo edge register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      trig_q <= 1'b0;
      dist_q <= '0;
      thr_q  <= 1'b0;
      pidx_q <= '0;
      tmo_q  <= 8'd0;
      echo_q <= 1'b0;
    end else begin
      trig_q <= trig_d;
      dist_q <= dist_d;
      thr_q  <= thr_d;
      pidx_q <= pidx_d;
      tmo_q  <= tmo_d;
      echo_q <= radar_echo;
    end
  end

  assign radar_pulse_trigger = trig_q;
  assign distance_to_target  = dist_q;
  assign threat_detected     = thr_q;
  assign ARTAU_state         = state_q;
  assign pulse_index         = pidx_q;
  assign scan_timeout_count  = tmo_q;

endmodule

// File: tb/tb_artau_multi_pulse.sv
// Randomised scan-level bench for artau_multi_pulse with a schedule-based model.
module tb_artau_multi_pulse;

  logic        CLK = 1'b0;
  logic        RST;
  logic        radar_echo, scan_for_target, continuous_mode;
  logic [31:0] max_safe_distance;
  logic        radar_pulse_trigger, threat_detected;
  logic [31:0] distance_to_target;
  logic [1:0]  ARTAU_state;
  logic [1:0]  pulse_index;
  logic [7:0]  scan_timeout_count;

  logic        echo4, scan4, cont4;
  logic [31:0] max4;
  logic        trig4, thr4;
  logic [31:0] dist4;
  logic [1:0]  st4;
  logic [2:0]  pidx4;
  logic [7:0]  tmo4;

  int n_cmp  = 0;
  int n_fail = 0;

  // Scan-level model state: what the outputs should hold between scans.
  logic [31:0] m_dist;
  bit          m_thr;
  int          m_tmo;

  typedef struct {
    int          st;
    int          pi;
    int          echo;
    logic [31:0] d;
    bit          t;
  } exp_t;

  always #5 CLK = ~CLK;

  artau_multi_pulse dut (
    .CLK(CLK), .RST(RST), .radar_echo(radar_echo), .scan_for_target(scan_for_target),
    .continuous_mode(continuous_mode), .max_safe_distance(max_safe_distance),
    .radar_pulse_trigger(radar_pulse_trigger), .distance_to_target(distance_to_target),
    .threat_detected(threat_detected), .ARTAU_state(ARTAU_state),
    .pulse_index(pulse_index), .scan_timeout_count(scan_timeout_count)
  );

  artau_multi_pulse #(.PULSES_PER_SCAN(4)) dut4 (
    .CLK(CLK), .RST(RST), .radar_echo(echo4), .scan_for_target(scan4),
    .continuous_mode(cont4), .max_safe_distance(max4),
    .radar_pulse_trigger(trig4), .distance_to_target(dist4),
    .threat_detected(thr4), .ARTAU_state(st4),
    .pulse_index(pidx4), .scan_timeout_count(tmo4)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Runs one 2-pulse scan. k=0 means no echo for that pulse (listen timeout),
  // otherwise the echo rises on listen cycle k. The expected per-cycle schedule
  // is laid out first from the scan rules, then driven and compared.
  task automatic run_scan(input int k0, input int k1, input logic [31:0] ms,
                          input bit from_idle, input bit exit_cont, input string nm);
    exp_t        q[$];
    exp_t        e;
    int          ks[2];
    int          lim, pi, fin_st, r;
    logic [31:0] d, prev;
    bit          t, sx, cx, timed_out;
    logic [5:0]  got, want;
    ks[0] = k0; ks[1] = k1;
    d = m_dist; prev = m_dist; t = m_thr; pi = 0; timed_out = 0;
    for (int p = 0; p < 2 && !timed_out; p++) begin
      for (int c = 0; c < 6; c++) begin
        e.st = 1; e.pi = pi; e.d = d; e.t = t;
        e.echo = (c < 5) ? int'($urandom_range(0, 1)) : 0;
        q.push_back(e);
      end
      lim = (ks[p] == 0) ? 40 : ks[p];
      for (int c = 1; c <= lim; c++) begin
        e.st = 2; e.pi = pi; e.d = d; e.t = t;
        e.echo = (c == ks[p]) ? 1 : 0;
        q.push_back(e);
      end
      if (ks[p] == 0) begin
        timed_out = 1; t = 0; pi = 0;
      end else begin
        prev = d; d = 32'(ks[p]) * 32'd7500; pi++;
      end
    end
    if (!timed_out) begin
      t = (d < prev) && (d < ms);
      for (int c = 0; c < 60; c++) begin
        e.st = 3; e.pi = pi; e.d = d; e.t = t;
        e.echo = int'($urandom_range(0, 1));
        q.push_back(e);
      end
      pi = 0;
    end
    fin_st = timed_out ? 0 : (exit_cont ? 1 : 0);
    if (exit_cont) begin
      sx = 1; cx = 1;
    end else begin
      r = int'($urandom_range(0, 2)); sx = (r == 2); cx = (r == 1);
    end

    max_safe_distance = ms;
    if (from_idle) begin
      scan_for_target = 1'b1;
      tick();
    end
    foreach (q[i]) begin
      radar_echo = (q[i].echo != 0);
      if (q[i].st == 3) begin
        scan_for_target = sx; continuous_mode = cx;
      end else begin
        scan_for_target = 1'($urandom_range(0, 1));
        continuous_mode = 1'($urandom_range(0, 1));
      end
      got  = {ARTAU_state, radar_pulse_trigger, threat_detected, pulse_index};
      want = {2'(q[i].st), (q[i].st == 1), q[i].t, 2'(q[i].pi)};
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s ctrl cyc %0d: got st=%0d trig=%0b thr=%0b pidx=%0d, want st=%0d trig=%0b thr=%0b pidx=%0d",
                 nm, i, got[5:4], got[3], got[2], got[1:0], want[5:4], want[3], want[2], want[1:0]);
      end
      n_cmp++;
      if (distance_to_target !== q[i].d) begin
        n_fail++;
        $display("FAIL %s dist cyc %0d: got %0d want %0d", nm, i, distance_to_target, q[i].d);
      end
      tick();
    end
    radar_echo = 1'b0;
    m_dist = d; m_thr = t;
    if (timed_out && m_tmo < 255) m_tmo++;

    got  = {ARTAU_state, radar_pulse_trigger, threat_detected, pulse_index};
    want = {2'(fin_st), (fin_st == 1), t, 2'(pi)};
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s end ctrl: got st=%0d trig=%0b thr=%0b pidx=%0d, want st=%0d trig=%0b thr=%0b pidx=%0d",
               nm, got[5:4], got[3], got[2], got[1:0], want[5:4], want[3], want[2], want[1:0]);
    end
    n_cmp++;
    if (distance_to_target !== d) begin
      n_fail++;
      $display("FAIL %s end dist: got %0d want %0d", nm, distance_to_target, d);
    end
    n_cmp++;
    if (scan_timeout_count !== 8'(m_tmo)) begin
      n_fail++;
      $display("FAIL %s timeouts: got %0d want %0d", nm, scan_timeout_count, m_tmo);
    end
    if (!exit_cont) scan_for_target = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({radar_pulse_trigger, distance_to_target, threat_detected, ARTAU_state, pulse_index, scan_timeout_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_main: got trig=%0b dist=%0d thr=%0b st=%0d pidx=%0d tmo=%0d, want all 0",
               radar_pulse_trigger, distance_to_target, threat_detected, ARTAU_state, pulse_index, scan_timeout_count);
    end
    n_cmp++;
    if ({trig4, dist4, thr4, st4, pidx4, tmo4} !== '0) begin
      n_fail++;
      $display("FAIL reset_p4: got trig=%0b dist=%0d st=%0d pidx=%0d, want all 0", trig4, dist4, st4, pidx4);
    end
    m_dist = '0; m_thr = 0; m_tmo = 0;
    RST = 1'b0;
  endtask

  task automatic test_first_scan();
    run_scan(4, 3, 32'd25000, 1, 0, "first_scan_threat");
  endtask

  task automatic test_threat();
    run_scan(4, 3, 32'd20000, 1, 0, "threat_above_max");
    run_scan(3, 4, 32'd25000, 1, 0, "receding");
    run_scan(5, 5, 32'd90000, 1, 0, "equal_dist");
    run_scan(4, 3, 32'd22501, 1, 0, "just_inside");
    run_scan(4, 3, 32'd22500, 1, 0, "at_threshold");
  endtask

  task automatic test_window();
    run_scan(40, 40, 32'd400000, 1, 0, "echo_last_cycle");
    run_scan(40, 39, 32'd400000, 1, 0, "echo_39_after_40");
    run_scan(0, 5, 32'd400000, 1, 0, "timeout_first");
    run_scan(7, 0, 32'd400000, 1, 0, "timeout_second");
    run_scan(1, 1, 32'd400000, 1, 0, "echo_first_cycle");
  endtask

  // Echo held high from IDLE through EMIT into LISTEN has no rising edge.
  task automatic test_echo_held();
    radar_echo = 1'b1;
    tick();
    scan_for_target = 1'b1;
    tick();
    scan_for_target = 1'b0;
    repeat (6) tick();
    n_cmp++;
    if (ARTAU_state !== 2'd2) begin
      n_fail++;
      $display("FAIL echo_held listen: got st=%0d want 2", ARTAU_state);
    end
    repeat (40) tick();
    if (m_tmo < 255) m_tmo++;
    m_thr = 0;
    n_cmp++;
    if ({ARTAU_state, threat_detected, pulse_index, scan_timeout_count, distance_to_target} !==
        {2'd0, 1'b0, 2'd0, 8'(m_tmo), m_dist}) begin
      n_fail++;
      $display("FAIL echo_held end: got st=%0d pidx=%0d tmo=%0d dist=%0d, want st=0 pidx=0 tmo=%0d dist=%0d",
               ARTAU_state, pulse_index, scan_timeout_count, distance_to_target, m_tmo, m_dist);
    end
    radar_echo = 1'b0;
  endtask

  task automatic test_continuous();
    run_scan(4, 3, 32'd25000, 1, 1, "cont_first");
    run_scan(6, 2, 32'd25000, 0, 1, "cont_second");
    run_scan(9, 12, 32'd25000, 0, 0, "cont_stop");
    continuous_mode = 1'b0;
  endtask

  task automatic test_timeout_sat();
    int extra;
    extra = 0;
    while (m_tmo < 255 || extra < 2) begin
      if (m_tmo == 255) extra++;
      run_scan(0, 0, 32'd0, 1, 0, "timeout_sat");
    end
  endtask

  task automatic test_random();
    bit emit_next, ec;
    int k0, k1;
    emit_next = 0;
    for (int n = 0; n < 30; n++) begin
      k0 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
      k1 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
      ec = (k0 != 0) && (k1 != 0) && ($urandom_range(0, 2) == 0);
      run_scan(k0, k1, $urandom_range(0, 320000), !emit_next, ec, "random");
      emit_next = ec;
    end
    continuous_mode = 1'b0;
  endtask

  // Reset asserted between clock edges after n cycles into a scan.
  task automatic test_reset_mid(input int n, input int want_st, input string nm);
    scan_for_target = 1'b1;
    tick();
    scan_for_target = 1'b0;
    repeat (n) tick();
    n_cmp++;
    if (ARTAU_state !== 2'(want_st)) begin
      n_fail++;
      $display("FAIL %s pre: got st=%0d want %0d", nm, ARTAU_state, want_st);
    end
    #3 RST = 1'b1;
    #1;
    n_cmp++;
    if ({radar_pulse_trigger, distance_to_target, threat_detected, ARTAU_state, pulse_index, scan_timeout_count} !== '0) begin
      n_fail++;
      $display("FAIL %s: got trig=%0b dist=%0d thr=%0b st=%0d pidx=%0d tmo=%0d, want all 0", nm,
               radar_pulse_trigger, distance_to_target, threat_detected, ARTAU_state, pulse_index, scan_timeout_count);
    end
    tick();
    RST = 1'b0;
    m_dist = '0; m_thr = 0; m_tmo = 0;
    tick();
    n_cmp++;
    if (ARTAU_state !== 2'd0) begin
      n_fail++;
      $display("FAIL %s post: got st=%0d want 0", nm, ARTAU_state);
    end
  endtask

  // Four-pulse variant: echo on the first listen cycle of every pulse.
  task automatic test_pulses4();
    int  emits;
    bit  reached;
    logic [1:0] prev_st;
    echo4 = 1'b0; cont4 = 1'b0; max4 = 32'd100000;
    scan4 = 1'b1;
    tick();
    scan4 = 1'b0;
    emits = 0; reached = 0; prev_st = 2'd0;
    for (int c = 0; c < 2000 && !reached; c++) begin
      if (st4 == 2'd1 && prev_st != 2'd1) emits++;
      if (st4 == 2'd3) begin
        reached = 1;
      end else begin
        echo4 = (st4 == 2'd2);
        prev_st = st4;
        tick();
      end
    end
    echo4 = 1'b0;
    n_cmp++;
    if (!reached) begin
      n_fail++;
      $display("FAIL p4 assess: got no ASSESS within bound, want ASSESS");
    end
    n_cmp++;
    if (emits !== 4) begin
      n_fail++;
      $display("FAIL p4 emits: got %0d want 4", emits);
    end
    n_cmp++;
    if ({pidx4, dist4, thr4} !== {3'd4, 32'd7500, 1'b0}) begin
      n_fail++;
      $display("FAIL p4 result: got pidx=%0d dist=%0d thr=%0b, want pidx=4 dist=7500 thr=0", pidx4, dist4, thr4);
    end
    repeat (60) tick();
    n_cmp++;
    if ({st4, pidx4} !== {2'd0, 3'd0}) begin
      n_fail++;
      $display("FAIL p4 exit: got st=%0d pidx=%0d want st=0 pidx=0", st4, pidx4);
    end
  endtask

  initial begin
    RST = 1'b1;
    radar_echo = 1'b0; scan_for_target = 1'b0; continuous_mode = 1'b0;
    max_safe_distance = '0;
    echo4 = 1'b0; scan4 = 1'b0; cont4 = 1'b0; max4 = '0;
    m_dist = '0; m_thr = 0; m_tmo = 0;

    test_reset();
    test_first_scan();
    test_threat();
    test_window();
    test_echo_held();
    test_continuous();
    test_pulses4();
    test_random();
    test_timeout_sat();
    test_reset_mid(2, 1, "reset_mid_emit");
    test_reset_mid(12, 2, "reset_mid_listen");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
